// File: rtl/kyber_pkg.sv
// Shared constants and FSM state type for the Kyber PMUL result unload path.
package kyber_pkg;

    localparam int COEF_W    = 12;
    localparam int N         = 256;
    localparam int PE_NUMBER = 4;
    localparam int WORDS     = N / PE_NUMBER;
    localparam int WIDX_W    = $clog2(WORDS);
    localparam int WORD_W    = PE_NUMBER * COEF_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_CAPTURE,
        ST_DRAIN
    } state_e;

endpackage

// File: rtl/kyber_coef_buf.sv
// 256-coefficient flop store: 4-wide write in multiplier BRAM interleaved order,
// 4-wide read in natural coefficient order.
module kyber_coef_buf
    import kyber_pkg::*;
(
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [WIDX_W-1:0] wr_idx_i,
    input  logic [WORD_W-1:0] wr_data_i,
    input  logic [WIDX_W-1:0] rd_idx_i,
    output logic [WORD_W-1:0] rd_data_o
);

    logic [COEF_W-1:0] mem_q [N];

    // Word j carries c[2j], c[2j+128], c[2j+1], c[2j+129]; the MSB of the
    // address selects the upper half, the LSB the odd coefficient.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[{1'b0, wr_idx_i, 1'b0}] <= wr_data_i[4*COEF_W-1:3*COEF_W];
            mem_q[{1'b1, wr_idx_i, 1'b0}] <= wr_data_i[3*COEF_W-1:2*COEF_W];
            mem_q[{1'b0, wr_idx_i, 1'b1}] <= wr_data_i[2*COEF_W-1:COEF_W];
            mem_q[{1'b1, wr_idx_i, 1'b1}] <= wr_data_i[COEF_W-1:0];
        end
    end

    assign rd_data_o = {mem_q[{rd_idx_i, 2'b00}],
                        mem_q[{rd_idx_i, 2'b01}],
                        mem_q[{rd_idx_i, 2'b10}],
                        mem_q[{rd_idx_i, 2'b11}]};

endmodule

// File: rtl/kyber_pmul_unload.sv
// Captures the 64-word interleaved dout burst of the 4-PE Kyber multiplier and
// re-emits the 256 coefficients in natural order on a valid/ready stream.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for start
// ST_WAIT    | counting down the multiplier read latency
// ST_CAPTURE | writing one dout word per cycle, j = 0..63
// ST_DRAIN   | presenting word i until handshake; then one done cycle
module kyber_pmul_unload #(
    parameter int PE_NUMBER = 4,
    parameter int COEF_W    = 12,
    parameter int READ_LAT  = 3,
    parameter int N         = 256
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [PE_NUMBER*COEF_W-1:0] din,
    output logic [PE_NUMBER*COEF_W-1:0] out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_last,
    output logic                        busy,
    output logic                        done
);
    import kyber_pkg::*;

    if (PE_NUMBER != 4 || PE_NUMBER != kyber_pkg::PE_NUMBER) begin : g_bad_pe
        $error("kyber_pmul_unload supports PE_NUMBER = 4 only");
    end
    if (COEF_W != kyber_pkg::COEF_W || N != kyber_pkg::N) begin : g_bad_geom
        $error("kyber_pmul_unload geometry must match kyber_pkg");
    end
    if (READ_LAT < 2) begin : g_bad_lat
        $error("kyber_pmul_unload needs READ_LAT >= 2");
    end

    localparam int CNT_W = $clog2(READ_LAT);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WIDX_W-1:0]   j_q, j_d;
    logic [WIDX_W-1:0]   i_q, i_d;
    logic [WORD_W-1:0]   data_q, data_d;
    logic                valid_q, valid_d;
    logic                done_q, done_d;

    logic                wr_en;
    logic [WIDX_W-1:0]   rd_idx;
    logic [WORD_W-1:0]   rd_data;
    logic                hs;

    assign hs = valid_q & out_ready;

    kyber_coef_buf u_buf (
        .clk       (clk),
        .wr_en_i   (wr_en),
        .wr_idx_i  (j_q),
        .wr_data_i (din),
        .rd_idx_i  (rd_idx),
        .rd_data_o (rd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            j_q     <= '0;
            i_q     <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            j_q     <= j_d;
            i_q     <= i_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        j_d     = j_q;
        i_d     = i_q;
        data_d  = data_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        wr_en   = 1'b0;
        rd_idx  = i_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_W'(READ_LAT - 1);
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_d == '0) begin
                    state_d = ST_CAPTURE;
                    j_d     = '0;
                end
            end
            ST_CAPTURE: begin
                wr_en = 1'b1;
                j_d   = j_q + 1'b1;
                // Word 0 only needs j = 0 and 1, so it can be preloaded here.
                if (j_q == WIDX_W'(WORDS - 1)) begin
                    state_d = ST_DRAIN;
                    i_d     = '0;
                    rd_idx  = '0;
                    data_d  = rd_data;
                    valid_d = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (done_q) begin
                    state_d = ST_IDLE;
                end else if (hs) begin
                    if (i_q == WIDX_W'(WORDS - 1)) begin
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        i_d    = i_q + 1'b1;
                        rd_idx = i_q + 1'b1;
                        data_d = rd_data;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign out_last  = valid_q && (i_q == WIDX_W'(WORDS - 1));
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;

endmodule

// File: tb/tb_kyber_pmul_unload.sv
// Scoreboard bench for kyber_pmul_unload: random polynomials, ready patterns,
// stray starts, mid-run reset and back-to-back runs.
module tb_kyber_pmul_unload;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [47:0] din = '0;
    logic [47:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_last;
    logic        busy;
    logic        done;

    kyber_pmul_unload dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .din       (din),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [11:0] poly [256];
    logic [47:0] exp_q [$];
    logic [47:0] got [64];
    int          pop_idx = 0;
    int          first_valid_cyc = -1;
    int          done_cyc = -1;
    int          done_cnt = 0;
    int          ready_mode = 0;
    logic [3:0]  pat = 4'b1001;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = pat[cyc % 4];
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: pops the scoreboard on every handshake, checks stalls and done.
    initial begin
        logic        prev_stall;
        logic        prev_last_hs;
        logic [47:0] prev_data;
        logic        prev_last;
        logic [47:0] e;
        prev_stall = 1'b0;
        prev_last_hs = 1'b0;
        prev_data = '0;
        prev_last = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_stall = 1'b0;
                prev_last_hs = 1'b0;
            end else begin
                if (prev_stall) begin
                    checks++;
                    if (!(out_valid && out_data == prev_data && out_last == prev_last)) begin
                        errors++;
                        $display("FAIL stall_hold cyc=%0d got v=%0b d=%h l=%0b want v=1 d=%h l=%0b",
                                 cyc, out_valid, out_data, out_last, prev_data, prev_last);
                    end
                end
                if (prev_last_hs) begin
                    checks++;
                    if (!(done && !out_valid)) begin
                        errors++;
                        $display("FAIL done_pulse cyc=%0d got done=%0b valid=%0b want done=1 valid=0",
                                 cyc, done, out_valid);
                    end
                end else if (done) begin
                    checks++;
                    errors++;
                    $display("FAIL done_unexpected cyc=%0d got done=1 want done=0", cyc);
                end
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
                prev_last_hs = 1'b0;
                if (out_valid && out_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL word_extra cyc=%0d got %h want no word", cyc, out_data);
                    end else begin
                        e = exp_q.pop_front();
                        if (out_data !== e || out_last !== (pop_idx == 63)) begin
                            errors++;
                            $display("FAIL word[%0d] got data=%h last=%0b want data=%h last=%0b",
                                     pop_idx, out_data, out_last, e, (pop_idx == 63));
                        end
                        if (pop_idx < 64) got[pop_idx] = out_data;
                        prev_last_hs = (pop_idx == 63);
                        pop_idx++;
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_data = out_data;
                prev_last = out_last;
            end
        end
    end

    task automatic chk(input bit ok, input string name, input logic [63:0] got_v, input logic [63:0] want_v);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got_v, want_v);
        end
    endtask

    task automatic do_run(input int mode, input bit extra, input int abort_j);
        int s;
        int dc0;
        int waited;
        bit busy_ok;
        ready_mode = mode;
        for (int i = 0; i < 64; i++)
            exp_q.push_back({poly[4*i], poly[4*i+1], poly[4*i+2], poly[4*i+3]});
        first_valid_cyc = -1;
        pop_idx = 0;
        dc0 = done_cnt;
        busy_ok = 1'b1;
        s = cyc;
        start = 1'b1;
        @(posedge clk); #1;
        start = extra;
        if (!busy) busy_ok = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        if (!busy) busy_ok = 1'b0;
        @(posedge clk); #1;
        for (int j = 0; j < 64; j++) begin
            if (!busy) busy_ok = 1'b0;
            din = {poly[2*j], poly[2*j+128], poly[2*j+1], poly[2*j+129]};
            start = extra && (j == 20);
            if (j == abort_j) begin
                reset = 1'b1;
                start = 1'b1;
                @(posedge clk); #1;
                reset = 1'b0;
                start = 1'b0;
                chk(!busy && !out_valid && !done, "abort_outputs",
                    {61'd0, busy, out_valid, done}, 64'd0);
                chk(busy_ok, "abort_busy_before", 64'(busy_ok), 64'd1);
                exp_q.delete();
                return;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        din = {16'($urandom), 32'($urandom)};
        waited = 0;
        while (!done && waited < 2000) begin
            if (!busy) busy_ok = 1'b0;
            start = extra && (cyc == s + 70);
            din = {16'($urandom), 32'($urandom)};
            @(posedge clk); #1;
            waited++;
        end
        start = 1'b0;
        if (!done) begin
            chk(1'b0, "done_timeout", 64'(waited), 64'd2000);
            return;
        end
        if (!busy) busy_ok = 1'b0;
        start = extra;
        @(posedge clk); #1;
        start = 1'b0;
        chk(!busy, "idle_after_done", 64'(busy), 64'd0);
        chk(busy_ok, "busy_through_run", 64'(busy_ok), 64'd1);
        chk(done_cnt - dc0 == 1, "done_count", 64'(done_cnt - dc0), 64'd1);
        chk(exp_q.size() == 0, "words_left", 64'(exp_q.size()), 64'd0);
        if (mode == 0) begin
            chk(first_valid_cyc - s == 67, "first_valid_lat", 64'(first_valid_cyc - s), 64'd67);
            chk(done_cyc - s == 131, "done_lat", 64'(done_cyc - s), 64'd131);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        start = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        start = 1'b0;
        chk(!busy, "reset_busy", 64'(busy), 64'd0);
        chk(!out_valid, "reset_valid", 64'(out_valid), 64'd0);
        chk(!done && !out_last, "reset_done_last", {62'd0, done, out_last}, 64'd0);
        chk(out_data == '0, "reset_data", 64'(out_data), 64'd0);
        repeat (2) begin
            @(posedge clk); #1;
        end

        // Ramp, ready tied high
        for (int k = 0; k < 256; k++) poly[k] = 12'(k);
        do_run(0, 1'b0, -1);
        chk(got[0] == 48'h000001002003, "ramp_word0", 64'(got[0]), 64'h000001002003);
        chk(got[63] == 48'h0FC0FD0FE0FF, "ramp_word63", 64'(got[63]), 64'h0FC0FD0FE0FF);
        repeat (3) begin
            @(posedge clk); #1;
        end

        // Backpressure 1,0,0,1 with a random polynomial
        for (int k = 0; k < 256; k++) poly[k] = 12'($urandom);
        do_run(1, 1'b0, -1);
        repeat (2) begin
            @(posedge clk); #1;
        end

        // Stray starts in WAIT, CAPTURE, DRAIN and the done cycle
        for (int k = 0; k < 256; k++) poly[k] = 12'(k);
        do_run(0, 1'b1, -1);
        chk(got[0] == 48'h000001002003, "extra_word0", 64'(got[0]), 64'h000001002003);
        chk(got[63] == 48'h0FC0FD0FE0FF, "extra_word63", 64'(got[63]), 64'h0FC0FD0FE0FF);
        repeat (2) begin
            @(posedge clk); #1;
        end

        // Reset at j = 20, then a full run with c[k] = 0xFFF - k
        for (int k = 0; k < 256; k++) poly[k] = 12'($urandom);
        do_run(0, 1'b0, 20);
        repeat (2) begin
            @(posedge clk); #1;
        end
        for (int k = 0; k < 256; k++) poly[k] = 12'(12'hFFF - k);
        do_run(2, 1'b0, -1);
        chk(got[0] == 48'hFFFFFEFFDFFC, "inv_word0", 64'(got[0]), 64'hFFFFFEFFDFFC);

        // Back-to-back: second start the cycle after done
        for (int k = 0; k < 256; k++) poly[k] = 12'($urandom);
        do_run(0, 1'b0, -1);
        for (int k = 0; k < 256; k++) poly[k] = 12'($urandom);
        do_run(2, 1'b0, -1);

        repeat (3) begin
            @(posedge clk); #1;
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
